// File: rtl/alu_pkg.sv
// alu_pkg: shared configuration checks and stage payload types for the
// pipelined adder/subtractor (pipelined_adder_sub and adder_slice).
package alu_pkg;

    localparam int unsigned DEF_WIDTH  = 32;
    localparam int unsigned DEF_STAGES = 4;

    // Width-independent part of the stage payload. The carry is passed from
    // slice k into slice k+1. The operand sign bits (b after inversion) are
    // carried down to the last stage for the signed-overflow flag.
    typedef struct packed {
        logic carry;
        logic a_msb;
        logic b_msb;
    } stage_ctl_t;

    // WIDTH must split into STAGES equal, non-empty slices.
    function automatic bit cfg_ok(
        input int unsigned width,
        input int unsigned stages
    );
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

    function automatic int unsigned slice_w(
        input int unsigned width,
        input int unsigned stages
    );
        return (stages == 0) ? width : width / stages;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// adder_slice: combinational C-bit ripple slice of full-adder cells.
// Ports: i_a/i_b operands, i_cin carry in -> o_s slice sum, o_cout carry out.
module adder_slice #(
    parameter int unsigned C = 8
) (
    input  logic [C-1:0] i_a,
    input  logic [C-1:0] i_b,
    input  logic         i_cin,
    output logic [C-1:0] o_s,
    output logic         o_cout
);

    logic w_c;

    always_comb begin
        w_c = i_cin;
        o_s = '0;
        for (int i = 0; i < int'(C); i++) begin
            o_s[i] = i_a[i] ^ i_b[i] ^ w_c;
            w_c    = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
        end
        o_cout = w_c;
    end

endmodule

// File: rtl/pipelined_adder_sub.sv
// pipelined_adder_sub: WIDTH-bit add/sub, carry chain split into STAGES slices,
// one slice per cycle, with a valid/ready handshake on input and output.
// Ports: clk, reset (sync, high); in_valid/in_ready, a, b, cin, sub in;
//        out_valid/out_ready, sum, cout, ovf, zero out.
module pipelined_adder_sub
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned C    = slice_w(WIDTH, STAGES);
    localparam int unsigned LAST = STAGES - 1;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("pipelined_adder_sub: need 1<=STAGES<=WIDTH, WIDTH%%STAGES==0");
    end

    logic [STAGES-1:0] r_vld;
    logic [STAGES-1:0] w_src_vld;
    logic [STAGES:0]   w_rdy;

    // w_rdy[k]: stage k may load this cycle (empty or its content leaves).
    // Walks from the output back, so in_ready never depends on in_valid.
    always_comb begin
        w_rdy         = '0;
        w_rdy[STAGES] = out_ready;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            w_rdy[k] = !r_vld[k] || w_rdy[k+1];
        end
    end

    always_comb begin
        w_src_vld    = r_vld << 1;
        w_src_vld[0] = in_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= '0;
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                if (w_rdy[k]) begin
                    r_vld[k] <= w_src_vld[k];
                end
            end
        end
    end

    assign in_ready  = w_rdy[0];
    assign out_valid = r_vld[LAST];

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int unsigned LO = k * C;
        // Operand bits entering this stage; partial-sum bits it produces.
        localparam int unsigned IW = WIDTH - LO;
        localparam int unsigned PW = LO + C;

        logic [IW-1:0] w_a_in;
        logic [IW-1:0] w_b_in;
        stage_ctl_t    w_ctl_in;
        logic [PW-1:0] w_ps_nxt;
        logic [C-1:0]  w_s;
        logic          w_c;
        logic          w_load;
        stage_ctl_t    r_ctl;
        logic [PW-1:0] r_ps;

        if (k == 0) begin : g_head
            logic [WIDTH-1:0] w_b_eff;

            // Subtract as a + ~b + 1; cin only matters in add mode.
            assign w_b_eff  = sub ? ~b : b;
            assign w_a_in   = a;
            assign w_b_in   = w_b_eff;
            assign w_ctl_in = '{
                carry: sub ? 1'b1 : cin,
                a_msb: a[WIDTH-1],
                b_msb: w_b_eff[WIDTH-1]
            };
            assign w_ps_nxt = w_s;
        end else begin : g_body
            assign w_a_in   = g_stg[k-1].g_ops.r_a;
            assign w_b_in   = g_stg[k-1].g_ops.r_b;
            assign w_ctl_in = g_stg[k-1].r_ctl;
            assign w_ps_nxt = {w_s, g_stg[k-1].r_ps};
        end

        adder_slice #(
            .C(C)
        ) u_slice (
            .i_a   (w_a_in[C-1:0]),
            .i_b   (w_b_in[C-1:0]),
            .i_cin (w_ctl_in.carry),
            .o_s   (w_s),
            .o_cout(w_c)
        );

        assign w_load = w_rdy[k] && w_src_vld[k];

        always_ff @(posedge clk) begin
            if (reset) begin
                r_ctl <= '0;
                r_ps  <= '0;
            end else if (w_load) begin
                r_ctl <= '{
                    carry: w_c,
                    a_msb: w_ctl_in.a_msb,
                    b_msb: w_ctl_in.b_msb
                };
                r_ps  <= w_ps_nxt;
            end
        end

        // Unprocessed high slices travel down; the last stage has none.
        if (IW > C) begin : g_ops
            logic [IW-C-1:0] r_a;
            logic [IW-C-1:0] r_b;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_load) begin
                    r_a <= w_a_in[IW-1:C];
                    r_b <= w_b_in[IW-1:C];
                end
            end
        end
    end

    stage_ctl_t w_ctl_out;

    assign sum       = g_stg[LAST].r_ps;
    assign w_ctl_out = g_stg[LAST].r_ctl;
    assign cout      = w_ctl_out.carry;
    assign ovf       = (w_ctl_out.a_msb == w_ctl_out.b_msb)
                    && (sum[WIDTH-1] != w_ctl_out.a_msb);
    // Gated by valid so the idle/reset output reads zero=0.
    assign zero      = out_valid && (sum == '0);

endmodule
